cascade_slave_responder: RTL and testbench

//  Slave-side end of the 8259 cascade bus. The master drives the selected slave ID on CASCADE during the INTA sequence.

---
 rtl/pic_cascade_pkg.sv | 7 +
 rtl/cascade_slave_responder_if.sv | 22 ++
 rtl/inta_edge_sync.sv | 29 ++
 rtl/cascade_slave_responder.sv | 87 ++++++++
 tb/tb_cascade_slave_responder.sv | 136 +++++++++++++
 5 files changed

// File: rtl/pic_cascade_pkg.sv
// pic_cascade_pkg: shared types and constants for the 8259 cascade logic
package pic_cascade_pkg;
  typedef enum logic [2:0] {IDLE, SKIP, W1, W2, D2, W3, D3} cas_state_t;
  localparam int INTA_CNT_8086 = 2;
  localparam int INTA_CNT_8080 = 3;
  localparam int CAS_W = 3;
endpackage

// File: rtl/cascade_slave_responder_if.sv
// cascade_slave_responder_if: cascade/INTA/data-bus signals of a slave PIC
interface cascade_slave_responder_if;
  import pic_cascade_pkg::*;
  logic inta_n;
  logic [CAS_W-1:0] cascade;
  logic spen;
  logic sngl;
  logic mode_8086;
  logic [CAS_W-1:0] slave_adress;
  logic [7:0] vec_byte2;
  logic [7:0] vec_byte3;
  logic ack;
  logic freeze;
  logic [7:0] data_out;
  logic data_oe;
  logic seq_done;
  logic seq_abort;
  modport master (output inta_n, cascade, spen, sngl, mode_8086, slave_adress, vec_byte2, vec_byte3,
                  input ack, freeze, data_out, data_oe, seq_done, seq_abort);
  modport slave (input inta_n, cascade, spen, sngl, mode_8086, slave_adress, vec_byte2, vec_byte3,
                 output ack, freeze, data_out, data_oe, seq_done, seq_abort);
endinterface

// File: rtl/inta_edge_sync.sv
// inta_edge_sync: synchronizes INTA_N and flags one-cycle fall/rise edges
module inta_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inta_n,
  output logic inta_sync,
  output logic fall,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sr;
  logic prev;
  logic [SYNC_STAGES:0] vld;
  // Synchronizer chain; edges are suppressed until the chain holds real pin samples so a low pin at reset release is not a fall
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr <= '1;
      prev <= 1'b1;
      vld <= '0;
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], inta_n};
      prev <= sr[SYNC_STAGES-1];
      vld <= {vld[SYNC_STAGES-1:0], 1'b1};
    end
  assign inta_sync = sr[SYNC_STAGES-1];
  assign fall = vld[SYNC_STAGES] & prev & ~inta_sync;
  assign rise = vld[SYNC_STAGES] & ~prev & inta_sync;
endmodule

// File: rtl/cascade_slave_responder.sv
// cascade_slave_responder: slave-side 8259 cascade responder driving vector bytes on owned INTA pulses
module cascade_slave_responder
  import pic_cascade_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  cascade_slave_responder_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) < 8 ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
  cas_state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] left;
  logic mode;
  logic inta_sync, fall, rise;
  inta_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .inta_n(bus.inta_n), .inta_sync(inta_sync), .fall(fall), .rise(rise)
  );
  // INTA sequencer with timeout counter and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      left <= '0;
      mode <= 1'b0;
      bus.ack <= 1'b0;
      bus.freeze <= 1'b0;
      bus.data_out <= 8'h00;
      bus.data_oe <= 1'b0;
      bus.seq_done <= 1'b0;
      bus.seq_abort <= 1'b0;
    end else begin
      bus.freeze <= 1'b0;
      bus.seq_done <= 1'b0;
      bus.seq_abort <= 1'b0;
      cnt <= (fall || rise || state == IDLE) ? '0 : cnt + 1'b1;
      if (state != IDLE && cnt == TMO) begin
        bus.seq_abort <= state != SKIP;
        bus.ack <= 1'b0;
        bus.data_oe <= 1'b0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (fall && !bus.spen && !bus.sngl) begin
            mode <= bus.mode_8086;
            if (bus.cascade == bus.slave_adress) begin
              bus.freeze <= 1'b1;
              bus.ack <= 1'b1;
              state <= W1;
            end else begin
              left <= bus.mode_8086 ? 2'(INTA_CNT_8086 - 1) : 2'(INTA_CNT_8080 - 1);
              state <= SKIP;
            end
          end
          SKIP: if (fall) left <= left - 1'b1;
                else if (rise && left == 2'd0) state <= IDLE;
          W1: if (rise) state <= W2;
          W2: if (fall) begin
            bus.data_out <= bus.vec_byte2;
            bus.data_oe <= 1'b1;
            state <= D2;
          end
          D2: if (rise) begin
            bus.data_oe <= 1'b0;
            bus.seq_done <= mode;
            bus.ack <= !mode;
            state <= mode ? IDLE : W3;
          end
          W3: if (fall) begin
            bus.data_out <= bus.vec_byte3;
            bus.data_oe <= 1'b1;
            state <= D3;
          end
          D3: if (rise) begin
            bus.data_oe <= 1'b0;
            bus.seq_done <= 1'b1;
            bus.ack <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_cascade_slave_responder.sv
// tb_cascade_slave_responder: directed self-checking bench for the cascade slave responder
module tb_cascade_slave_responder;
  localparam int TMO = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int errs = 0;
  int nf = 0, nd = 0, na = 0;
  int f0, d0, a0;
  cascade_slave_responder_if bus();
  cascade_slave_responder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  // Pulse counters for the one-cycle strobes
  always @(negedge clk) begin
    nf <= nf + int'(bus.freeze);
    nd <= nd + int'(bus.seq_done);
    na <= nd >= 0 ? na + int'(bus.seq_abort) : na;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic snap();
    f0 = nf; d0 = nd; a0 = na;
  endtask
  task automatic pulse(input string tag, input logic exp_oe, input logic [7:0] exp_d);
    bus.inta_n = 1'b0;
    repeat (5) @(negedge clk);
    chk({tag, "_oe"}, 32'(bus.data_oe), 32'(exp_oe));
    if (exp_oe) chk({tag, "_data"}, 32'(bus.data_out), 32'(exp_d));
    bus.inta_n = 1'b1;
    repeat (6) @(negedge clk);
    chk({tag, "_oe_off"}, 32'(bus.data_oe), 32'd0);
  endtask
  task automatic set_bus(input logic [2:0] cas, input logic spen, input logic m86, input logic [7:0] b2, input logic [7:0] b3);
    bus.cascade = cas; bus.spen = spen; bus.mode_8086 = m86; bus.vec_byte2 = b2; bus.vec_byte3 = b3;
  endtask
  initial begin
    bus.inta_n = 1'b1; bus.sngl = 1'b0; bus.slave_adress = 3'd5;
    set_bus(3'd5, 1'b0, 1'b1, 8'h4D, 8'h00);
    // 1: reset with INTA toggling
    repeat (6) begin @(negedge clk); bus.inta_n = ~bus.inta_n; end
    bus.inta_n = 1'b1;
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_oe", 32'(bus.data_oe), 32'd0);
    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_strobes", 32'({bus.freeze, bus.seq_done, bus.seq_abort}), 32'd0);
    snap();
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rel_freeze", 32'(nf - f0), 32'd0);
    chk("rel_ack", 32'(bus.ack), 32'd0);
    // 2: 8086 match
    snap();
    pulse("m86_i1", 1'b0, 8'h00);
    chk("m86_freeze", 32'(nf - f0), 32'd1);
    chk("m86_ack1", 32'(bus.ack), 32'd1);
    pulse("m86_i2", 1'b1, 8'h4D);
    chk("m86_done", 32'(nd - d0), 32'd1);
    chk("m86_ack_end", 32'(bus.ack), 32'd0);
    chk("m86_hold", 32'(bus.data_out), 32'h4D);
    // 3: 8080 match
    set_bus(3'd5, 1'b0, 1'b0, 8'h20, 8'h01);
    snap();
    pulse("m80_i1", 1'b0, 8'h00);
    pulse("m80_i2", 1'b1, 8'h20);
    chk("m80_ack2", 32'(bus.ack), 32'd1);
    chk("m80_nodone", 32'(nd - d0), 32'd0);
    pulse("m80_i3", 1'b1, 8'h01);
    chk("m80_done", 32'(nd - d0), 32'd1);
    chk("m80_freeze", 32'(nf - f0), 32'd1);
    chk("m80_ack_end", 32'(bus.ack), 32'd0);
    // 4: ID mismatch, then master-configured
    set_bus(3'd3, 1'b0, 1'b1, 8'h77, 8'h00);
    snap();
    pulse("mis_i1", 1'b0, 8'h00);
    chk("mis_ack", 32'(bus.ack), 32'd0);
    pulse("mis_i2", 1'b0, 8'h00);
    set_bus(3'd5, 1'b1, 1'b1, 8'h77, 8'h00);
    pulse("spen_i1", 1'b0, 8'h00);
    chk("spen_ack", 32'(bus.ack), 32'd0);
    pulse("spen_i2", 1'b0, 8'h00);
    chk("dis_freeze", 32'(nf - f0), 32'd0);
    chk("dis_done", 32'(nd - d0), 32'd0);
    chk("dis_data", 32'(bus.data_out), 32'h01);
    set_bus(3'd5, 1'b0, 1'b1, 8'hA5, 8'h00);
    snap();
    pulse("rec_i1", 1'b0, 8'h00);
    pulse("rec_i2", 1'b1, 8'hA5);
    chk("rec_done", 32'(nd - d0), 32'd1);
    // 5: timeout after INTA #1
    set_bus(3'd5, 1'b0, 1'b1, 8'h33, 8'h00);
    snap();
    pulse("to_i1", 1'b0, 8'h00);
    chk("to_ack_pre", 32'(bus.ack), 32'd1);
    repeat (TMO + 5) @(negedge clk);
    chk("to_abort", 32'(na - a0), 32'd1);
    chk("to_ack", 32'(bus.ack), 32'd0);
    chk("to_nodone", 32'(nd - d0), 32'd0);
    snap();
    pulse("to2_i1", 1'b0, 8'h00);
    pulse("to2_i2", 1'b1, 8'h33);
    chk("to2_done", 32'(nd - d0), 32'd1);
    chk("to2_noabort", 32'(na - a0), 32'd0);
    // 6: async reset during owned INTA #2
    set_bus(3'd5, 1'b0, 1'b1, 8'hC3, 8'h00);
    snap();
    pulse("ar_i1", 1'b0, 8'h00);
    bus.inta_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("ar_oe_pre", 32'(bus.data_oe), 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_oe", 32'(bus.data_oe), 32'd0);
    chk("ar_ack", 32'(bus.ack), 32'd0);
    chk("ar_data", 32'(bus.data_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    snap();
    repeat (8) @(negedge clk);
    chk("ar_lowpin_freeze", 32'(nf - f0), 32'd0);
    chk("ar_lowpin_ack", 32'(bus.ack), 32'd0);
    bus.inta_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("ar_nodone", 32'(nd - d0), 32'd0);
    snap();
    pulse("ar2_i1", 1'b0, 8'h00);
    pulse("ar2_i2", 1'b1, 8'hC3);
    chk("ar2_done", 32'(nd - d0), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
